// File: rtl/adder_seq_ctrl_if.sv
// Bus bundle for adder_seq_ctrl: byte receive strobe, operand/adder handshake,
// byte transmit handshake and status.
interface adder_seq_ctrl_if;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic [380:0] op_a;
    logic [380:0] op_b;
    logic         add_start;
    logic         add_done;
    logic [381:0] add_sum;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic [1:0]   err;

    modport slave (
        input  rx_valid,
        input  rx_byte,
        output op_a,
        output op_b,
        output add_start,
        input  add_done,
        input  add_sum,
        output tx_byte,
        output tx_valid,
        input  tx_ready,
        output busy,
        output err
    );

    modport master (
        output rx_valid,
        output rx_byte,
        input  op_a,
        input  op_b,
        input  add_start,
        output add_done,
        output add_sum,
        input  tx_byte,
        input  tx_valid,
        output tx_ready,
        input  busy,
        input  err
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Sequencer: assembles two MSB-first byte frames into adder operands, launches
// the adder, waits (bounded) for its result and streams the result out bytewise.
module adder_seq_ctrl #(
    parameter int NBYTES  = 48,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    adder_seq_ctrl_if.slave bus
);

    localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [5:0]       LAST_IDX = 6'(NBYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RX_A     = 3'd0,
        ST_RX_B     = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_ADD = 3'd3,
        ST_TX       = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [383:0]       shadow_q, shadow_d;
    logic [383:0]       result_q, result_d;
    logic [380:0]       op_a_q, op_a_d;
    logic [380:0]       op_b_q, op_b_d;
    logic               add_start_q, add_start_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               busy_q, busy_d;
    logic [1:0]         err_q, err_d;
    logic               last_byte_s;
    logic               tx_fire_s;
    logic               rx_drop_s;

    // Byte k of a frame sits MSB-first: byte 0 occupies the top used byte lane.
    function automatic logic [8:0] byte_lsb(input logic [5:0] k);
        return 9'((NBYTES - 1 - int'(k)) * 8);
    endfunction

    function automatic logic [7:0] byte_of(input logic [383:0] v, input logic [5:0] k);
        logic [383:0] sh;
        sh = v >> byte_lsb(k);
        return sh[7:0];
    endfunction

    assign last_byte_s = (cnt_q == LAST_IDX);
    assign tx_fire_s   = tx_valid_q & bus.tx_ready;
    assign rx_drop_s   = bus.rx_valid & ((state_q == ST_START) | (state_q == ST_WAIT_ADD) |
                                         (state_q == ST_TX));

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        result_d = result_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        err_d    = err_q;

        case (state_q)
            ST_RX_A, ST_RX_B: begin
                if (bus.rx_valid) begin
                    shadow_d[byte_lsb(cnt_q) +: 8] = bus.rx_byte;
                    if (last_byte_s) begin
                        cnt_d = 6'd0;
                        if (state_q == ST_RX_A) begin
                            op_a_d  = shadow_d[380:0];
                            state_d = ST_RX_B;
                        end else begin
                            op_b_d  = shadow_d[380:0];
                            state_d = ST_START;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_START: begin
                tmo_d   = {TMO_W{1'b0}};
                state_d = ST_WAIT_ADD;
            end
            ST_WAIT_ADD: begin
                // A completion on the final allowed cycle still wins over the abort.
                if (bus.add_done) begin
                    result_d = {2'b00, bus.add_sum};
                    cnt_d    = 6'd0;
                    state_d  = ST_TX;
                end else if (tmo_q == TMO_LAST) begin
                    cnt_d    = 6'd0;
                    err_d[1] = 1'b1;
                    state_d  = ST_RX_A;
                end else begin
                    tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_TX: begin
                if (tx_fire_s) begin
                    if (last_byte_s) begin
                        cnt_d   = 6'd0;
                        state_d = ST_RX_A;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d   = 6'd0;
                state_d = ST_RX_A;
            end
        endcase

        if (rx_drop_s) begin
            err_d[0] = 1'b1;
        end else begin
            err_d[0] = err_d[0];
        end

        add_start_d = (state_d == ST_START);
        tx_valid_d  = (state_d == ST_TX);
        busy_d      = !((state_d == ST_RX_A) && (cnt_d == 6'd0));
        if (tx_valid_d) begin
            tx_byte_d = byte_of(result_d, cnt_d);
        end else begin
            tx_byte_d = 8'h00;
        end
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RX_A;
            cnt_q       <= 6'd0;
            tmo_q       <= {TMO_W{1'b0}};
            shadow_q    <= 384'd0;
            result_q    <= 384'd0;
            op_a_q      <= 381'd0;
            op_b_q      <= 381'd0;
            add_start_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
            busy_q      <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            shadow_q    <= shadow_d;
            result_q    <= result_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            add_start_q <= add_start_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.add_start = add_start_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl: frame assembly, adder handshake, byte
// streaming with and without back-pressure, timeout, overrun and reset aborts.
module tb_adder_seq_ctrl;

    localparam int NB  = 48;
    localparam int TMO = 1024;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails = 0;
    int   start_pulses = 0;

    logic [7:0] tx_log [0:NB-1];
    int         tx_n;
    int         stall_cnt;
    int         stall_bad;

    adder_seq_ctrl_if bus();

    adder_seq_ctrl #(.NBYTES(NB), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.add_start === 1'b1) start_pulses <= start_pulses + 1;
    end

    // Frame whose byte k equals first + k*step, packed MSB-first.
    function automatic logic [383:0] pack_seq(input logic [7:0] first, input logic [7:0] step);
        logic [383:0] v;
        logic [7:0]   b;
        v = 384'd0;
        b = first;
        for (int k = 0; k < NB; k++) begin
            v = {v[375:0], b};
            b = b + step;
        end
        return v;
    endfunction

    function automatic logic [7:0] byte_at(input logic [383:0] v, input int k);
        logic [383:0] sh;
        sh = v >> ((NB - 1 - k) * 8);
        return sh[7:0];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] first, input logic [7:0] step, input int n);
        logic [7:0] b;
        b = first;
        for (int k = 0; k < n; k++) begin
            send_byte(b);
            b = b + step;
        end
    endtask

    task automatic adder_reply(input logic [381:0] sum);
        repeat (5) @(negedge clk);
        bus.add_done = 1'b1;
        bus.add_sum  = sum;
        @(negedge clk);
        bus.add_done = 1'b0;
        bus.add_sum  = 382'd0;
    endtask

    task automatic drain_tx(input bit throttle);
        int         cyc;
        logic [7:0] prev;
        bit         stalled;
        bit         rdy;
        cyc = 0;
        stalled = 1'b0;
        prev = 8'h00;
        tx_n = 0;
        stall_cnt = 0;
        stall_bad = 0;
        while (tx_n < NB && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                stall_cnt++;
                if (bus.tx_valid !== 1'b1 || bus.tx_byte !== prev) stall_bad++;
            end
            rdy = throttle ? ((cyc % 3) == 0) : 1'b1;
            bus.tx_ready = rdy;
            stalled = (bus.tx_valid === 1'b1) && !rdy;
            prev = bus.tx_byte;
            if (bus.tx_valid === 1'b1 && rdy) begin
                tx_log[tx_n] = bus.tx_byte;
                tx_n++;
            end
        end
        @(negedge clk);
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.add_done = 1'b0;
        bus.add_sum  = 382'd0;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.op_a !== 381'd0) begin fails++; $display("FAIL reset_op_a: got %h want 0", bus.op_a); end
        checks++; if (bus.op_b !== 381'd0) begin fails++; $display("FAIL reset_op_b: got %h want 0", bus.op_b); end
        checks++; if (bus.add_start !== 1'b0) begin fails++; $display("FAIL reset_add_start: got %b want 0", bus.add_start); end
        checks++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        checks++; if (bus.tx_byte !== 8'h00) begin fails++; $display("FAIL reset_tx_byte: got %h want 00", bus.tx_byte); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.err !== 2'b00) begin fails++; $display("FAIL reset_err: got %b want 00", bus.err); end
        reset = 1'b0;
    endtask

    task automatic test_frames;
        logic [383:0] exp_a;
        int           p0;
        exp_a = pack_seq(8'h00, 8'h01);
        p0 = start_pulses;
        send_byte(8'h00);
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL busy_first_byte: got %b want 1", bus.busy); end
        send_frame(8'h01, 8'h01, NB - 1);
        checks++; if (bus.op_a !== exp_a[380:0]) begin fails++; $display("FAIL op_a_ramp: got %h want %h", bus.op_a, exp_a[380:0]); end
        checks++; if (bus.add_start !== 1'b0) begin fails++; $display("FAIL add_start_after_a: got %b want 0", bus.add_start); end
        send_frame(8'hFF, 8'h00, NB);
        checks++; if (bus.op_b !== {381{1'b1}}) begin fails++; $display("FAIL op_b_ones: got %h", bus.op_b); end
        checks++; if (bus.add_start !== 1'b1) begin fails++; $display("FAIL add_start_pulse: got %b want 1", bus.add_start); end
        @(negedge clk);
        checks++; if (bus.add_start !== 1'b0) begin fails++; $display("FAIL add_start_width: got %b want 0", bus.add_start); end
        checks++; if (start_pulses - p0 !== 1) begin fails++; $display("FAIL add_start_count: got %0d want 1", start_pulses - p0); end
    endtask

    task automatic test_tx_full;
        logic [7:0] exp;
        adder_reply(382'h1);
        drain_tx(1'b0);
        checks++; if (tx_n !== NB) begin fails++; $display("FAIL tx_full_count: got %0d want %0d", tx_n, NB); end
        for (int k = 0; k < tx_n; k++) begin
            exp = (k == NB - 1) ? 8'h01 : 8'h00;
            checks++; if (tx_log[k] !== exp) begin fails++; $display("FAIL tx_full_byte%0d: got %h want %h", k, tx_log[k], exp); end
        end
        checks++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL tx_full_valid_end: got %b want 0", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL tx_full_busy_end: got %b want 0", bus.busy); end
    endtask

    task automatic test_tx_throttle;
        logic [383:0] res;
        logic [383:0] exp_a;
        res   = pack_seq(8'h00, 8'h01);
        exp_a = pack_seq(8'h11, 8'h00);
        send_frame(8'h11, 8'h00, NB);
        send_frame(8'h22, 8'h00, NB);
        checks++; if (bus.op_a !== exp_a[380:0]) begin fails++; $display("FAIL thr_op_a: got %h want %h", bus.op_a, exp_a[380:0]); end
        adder_reply(res[381:0]);
        drain_tx(1'b1);
        checks++; if (tx_n !== NB) begin fails++; $display("FAIL thr_count: got %0d want %0d", tx_n, NB); end
        for (int k = 0; k < tx_n; k++) begin
            checks++; if (tx_log[k] !== 8'(k)) begin fails++; $display("FAIL thr_byte%0d: got %h want %h", k, tx_log[k], 8'(k)); end
        end
        checks++; if (stall_cnt === 0) begin fails++; $display("FAIL thr_stalls: got %0d want >0", stall_cnt); end
        checks++; if (stall_bad !== 0) begin fails++; $display("FAIL thr_stable: got %0d unstable cycles want 0", stall_bad); end
        checks++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL thr_valid_end: got %b want 0", bus.tx_valid); end
    endtask

    task automatic test_timeout;
        logic [383:0] exp_a;
        int           seen_tx;
        exp_a = pack_seq(8'h5A, 8'h00);
        seen_tx = 0;
        send_frame(8'h5A, 8'h00, NB);
        send_frame(8'hA5, 8'h00, NB);
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (bus.tx_valid === 1'b1) seen_tx++;
        end
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL tmo_busy_before: got %b want 1", bus.busy); end
        checks++; if (bus.err !== 2'b00) begin fails++; $display("FAIL tmo_err_before: got %b want 00", bus.err); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL tmo_busy_after: got %b want 0", bus.busy); end
        checks++; if (bus.err !== 2'b10) begin fails++; $display("FAIL tmo_err_after: got %b want 10", bus.err); end
        checks++; if (seen_tx !== 0) begin fails++; $display("FAIL tmo_no_tx: got %0d tx cycles want 0", seen_tx); end
        checks++; if (bus.op_a !== exp_a[380:0]) begin fails++; $display("FAIL tmo_op_a: got %h want %h", bus.op_a, exp_a[380:0]); end
        bus.add_done = 1'b1;
        bus.add_sum  = 382'h7;
        @(negedge clk);
        bus.add_done = 1'b0;
        bus.add_sum  = 382'd0;
        repeat (3) @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL done_ignored_idle: got tx_valid=%b busy=%b want 0 0", bus.tx_valid, bus.busy);
        end
    endtask

    task automatic test_overrun;
        logic [383:0] exp_a;
        logic [383:0] exp_b;
        logic [383:0] res;
        exp_a = pack_seq(8'h33, 8'h00);
        exp_b = pack_seq(8'h44, 8'h00);
        res   = pack_seq(8'h3F, 8'hFF);
        send_frame(8'h33, 8'h00, NB);
        send_frame(8'h44, 8'h00, NB);
        @(negedge clk);
        send_byte(8'hAA);
        checks++; if (bus.err !== 2'b11) begin fails++; $display("FAIL ovr_err: got %b want 11", bus.err); end
        checks++; if (bus.op_a !== exp_a[380:0]) begin fails++; $display("FAIL ovr_op_a: got %h want %h", bus.op_a, exp_a[380:0]); end
        checks++; if (bus.op_b !== exp_b[380:0]) begin fails++; $display("FAIL ovr_op_b: got %h want %h", bus.op_b, exp_b[380:0]); end
        adder_reply(res[381:0]);
        drain_tx(1'b0);
        checks++; if (tx_n !== NB) begin fails++; $display("FAIL ovr_count: got %0d want %0d", tx_n, NB); end
        for (int k = 0; k < tx_n; k++) begin
            checks++; if (tx_log[k] !== byte_at(res, k)) begin fails++; $display("FAIL ovr_byte%0d: got %h want %h", k, tx_log[k], byte_at(res, k)); end
        end
        checks++; if (bus.err !== 2'b11) begin fails++; $display("FAIL ovr_err_sticky: got %b want 11", bus.err); end
    endtask

    task automatic test_reset_midframe;
        logic [383:0] exp_a;
        logic [383:0] exp_b;
        int           p0;
        exp_a = pack_seq(8'h50, 8'h01);
        exp_b = pack_seq(8'h80, 8'h01);
        send_frame(8'hEE, 8'h00, 20);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        p0 = start_pulses;
        checks++; if (bus.err !== 2'b00) begin fails++; $display("FAIL rst_mid_err: got %b want 00", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        send_frame(8'h50, 8'h01, NB);
        send_frame(8'h80, 8'h01, NB);
        checks++; if (bus.op_a !== exp_a[380:0]) begin fails++; $display("FAIL rst_mid_op_a: got %h want %h", bus.op_a, exp_a[380:0]); end
        checks++; if (bus.op_b !== exp_b[380:0]) begin fails++; $display("FAIL rst_mid_op_b: got %h want %h", bus.op_b, exp_b[380:0]); end
        @(negedge clk);
        checks++; if (start_pulses - p0 !== 1) begin fails++; $display("FAIL rst_mid_starts: got %0d want 1", start_pulses - p0); end
        adder_reply(382'h5);
        drain_tx(1'b0);
        checks++; if (tx_n !== NB || tx_log[NB-1] !== 8'h05) begin
            fails++; $display("FAIL rst_mid_result: got count %0d last %h want %0d 05", tx_n, tx_log[NB-1], NB);
        end
    endtask

    task automatic test_reset_mid_tx;
        int wait_cyc;
        int p0;
        int seen;
        send_frame(8'h01, 8'h00, NB);
        send_frame(8'h02, 8'h00, NB);
        adder_reply(382'h3);
        wait_cyc = 0;
        while (bus.tx_valid !== 1'b1 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++; if (bus.tx_valid !== 1'b1) begin fails++; $display("FAIL rst_tx_reach: got tx_valid=%b want 1", bus.tx_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        p0 = start_pulses;
        seen = 0;
        checks++; if (bus.tx_valid !== 1'b0 || bus.tx_byte !== 8'h00) begin
            fails++; $display("FAIL rst_tx_abort: got tx_valid=%b tx_byte=%h want 0 00", bus.tx_valid, bus.tx_byte);
        end
        bus.tx_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.tx_valid === 1'b1) seen++;
        end
        bus.tx_ready = 1'b0;
        checks++; if (seen !== 0 || start_pulses !== p0) begin
            fails++; $display("FAIL rst_tx_quiet: got %0d tx cycles %0d starts want 0 0", seen, start_pulses - p0);
        end
    endtask

    initial begin
        test_reset;
        test_frames;
        test_tx_full;
        test_tx_throttle;
        test_timeout;
        test_overrun;
        test_reset_midframe;
        test_reset_mid_tx;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NBYTES, default 48: bytes per operand frame and per result frame.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: maximum cycles spent in WAIT_ADD before abort.
REQ-003 The block SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port rx_valid, input, 1: one-cycle strobe, one received byte available.
REQ-006 The block SHALL have port rx_byte, input, 8: received byte, sampled only when rx_valid=1.
REQ-007 The block SHALL have port op_a, output, 381: operand A register.
REQ-008 The block SHALL have port op_b, output, 381: operand B register.
REQ-009 The block SHALL have port add_start, output, 1: one-cycle pulse launching the adder.
REQ-010 The block SHALL have port add_done, input, 1: adder completion strobe.
REQ-011 The block SHALL have port add_sum, input, 382: adder result, carry in bit 381, valid when add_done=1.
REQ-012 The block SHALL have port tx_byte, output, 8: byte offered to the transmitter.
REQ-013 The block SHALL have port tx_valid, output, 1: tx_byte valid; transfer occurs when tx_valid=1 and tx_ready=1.
REQ-014 The block SHALL have port tx_ready, input, 1: transmitter can accept a byte.
REQ-015 The block SHALL have port busy, output, 1: high in every state except RX_A with byte count 0.
REQ-016 The block SHALL have port err, output, 2: sticky flags, bit0 overrun, bit1 timeout.

Function
REQ-017 The FSM SHALL have states RX_A, RX_B, START, WAIT_ADD, TX; RX_A after reset.
REQ-018 In RX_A/RX_B each rx_valid byte SHALL be written MSB-first into a 384-bit shadow: k-th byte (k=0..NBYTES-1) to bits [(NBYTES-1-k)*8 +: 8]; operand = shadow[380:0].
REQ-019 The byte counter SHALL be 6 bits, increment per accepted byte, and clear when it reaches NBYTES-1 and a byte is accepted (wrap, no overflow).
REQ-020 Accepting byte NBYTES-1 SHALL transition RX_A->RX_B (op_a updated same edge) and RX_B->START (op_b updated same edge).
REQ-021 START SHALL last exactly one cycle with add_start=1, then go to WAIT_ADD; add_start SHALL be 0 in every other state.
REQ-022 add_done SHALL be ignored outside WAIT_ADD; in WAIT_ADD it SHALL latch {2'b00, add_sum} into a 384-bit result register and enter TX next cycle.
REQ-023 If WAIT_ADD lasts TIMEOUT cycles without add_done, FSM SHALL go to RX_A, counter cleared, err[1] set.
REQ-024 In TX, tx_valid SHALL be 1 and tx_byte SHALL equal result byte k (MSB-first, same mapping as REQ-018), held stable until tx_ready=1.
REQ-025 Each TX handshake SHALL advance k; handshake on byte NBYTES-1 SHALL return to RX_A with tx_valid=0 next cycle.
REQ-026 rx_valid in START, WAIT_ADD or TX SHALL drop the byte and set err[0]; it SHALL not alter op_a, op_b or counters.
REQ-027 err bits SHALL remain set until reset; they SHALL not stall the FSM.
REQ-028 op_a and op_b SHALL hold their values from the last completed frames until overwritten by a new completed frame.

Reset
REQ-029 Reset SHALL force state RX_A, counters 0, shadow/result/op_a/op_b 0, add_start=0, tx_valid=0, tx_byte=0, busy=0, err=0.
REQ-030 Reset asserted mid-frame, mid-WAIT_ADD or mid-TX SHALL abort immediately; partial frames SHALL be discarded and no further add_start or tx_valid issued.

Verification
REQ-031 Bench SHALL send 48 bytes 0x00..0x2F then 48 bytes 0xFF -> op_a=shadow[380:0] of 0x0001..2F, op_b=all ones, add_start single pulse the cycle after last B byte.
REQ-032 Bench SHALL return add_done with add_sum=382'h1 after 5 cycles, tx_ready=1 always -> 48 bytes out, first 47 = 0x00, last = 0x01, then busy=0.
REQ-033 Bench SHALL toggle tx_ready 1-in-3 cycles -> each tx_byte stable while tx_valid=1 and tx_ready=0, no byte lost or duplicated.
REQ-034 Bench SHALL never assert add_done -> after TIMEOUT cycles FSM in RX_A, err=2'b10, no tx_valid.
REQ-035 Bench SHALL pulse rx_valid during WAIT_ADD -> err[0]=1, op_a/op_b unchanged, result transmitted normally.
REQ-036 Bench SHALL assert reset after 20 A bytes, then send 96 fresh bytes -> op_a/op_b reflect only post-reset bytes.
